exp_priority16: RTL and testbench
=================================

EXP_PRIORITY16 -- requirements
Module: exp_priority16

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 16 bits.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port clk: input, 1 bit, rising-edge clock for all state.
REQ-004 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-005 Port Din: input, 16 bits, request vector; bit 15 has highest priority, bit 0 lowest.
REQ-006 Port En: input, 1 bit, active-low enable (0 = encode, 1 = disabled).
REQ-007 Port Dout: output, 4 bits, registered index of the highest-priority set bit of Din.
REQ-008 Port Valid: output, 1 bit, registered flag; 1 when Dout holds a real encoding.

Function
REQ-009 Combinational next-value logic SHALL scan Din from bit 15 down to bit 0 and select the first bit equal to 1.
REQ-010 The selected index i SHALL be encoded as unsigned binary: Din[15] set -> 4'hF, ..., Din[0] set -> 4'h0.
REQ-011 Bits below the selected bit SHALL be don't-care: their 0, 1, X or Z value SHALL NOT affect Dout or Valid.
REQ-012 X/Z on bits below the highest 1 SHALL NOT propagate X to Dout or Valid; use a priority scan, not arithmetic or reduction over all bits.
REQ-013 Dout and Valid SHALL be registered on the rising edge of clk, giving a latency of exactly 1 cycle from Din/En to output.
REQ-014 With En=0 and at least one Din bit set, the next edge SHALL load the encoded index into Dout and set Valid=1.
REQ-015 With En=0 and Din=16'h0000, the next edge SHALL load Dout=4'h0 and Valid=0.
REQ-016 With En=1, the next edge SHALL load Dout=4'h0 and Valid=0 regardless of Din, including X bits.
REQ-017 Dout=4'h0 with Valid=1 SHALL mean bit 0 was the only set bit; Dout=4'h0 with Valid=0 SHALL mean no request or disabled.
REQ-018 Outputs SHALL change only on a clk rising edge or on reset assertion, and SHALL be glitch-free registers.
REQ-019 A new Din value SHALL be accepted every cycle, with no handshake and no back-pressure.

Reset
REQ-020 While rst_n=0, Dout SHALL be 4'h0 and Valid SHALL be 0, set asynchronously and independent of clk.
REQ-021 Asserting reset mid-operation SHALL immediately force Dout=4'h0 and Valid=0; any pending next value SHALL be discarded.
REQ-022 After rst_n deasserts, the first rising edge SHALL load the normal encoding of the current Din and En.

Verification
REQ-023 Walking priority: with En=0, apply Din=16'b0000_0000_0000_0001, then 16'b...01X, and so on up to 16'b1XXX_XXXX_XXXX_XXXX, one per 10 ns cycle; Dout SHALL step 0,1,...,15 one cycle later each time, with Valid=1 and no X on the outputs.
REQ-024 Zero input: En=0, Din=16'h0000 -> Dout=4'h0, Valid=0 after one edge.
REQ-025 Disable: En=1, Din=16'h8001 -> Dout=4'h0, Valid=0; then En=0 -> Dout=4'hF, Valid=1 on the following edge.
REQ-026 Multi-hot: Din=16'h0A50 with En=0 -> Dout=4'hB, Valid=1; Din=16'hFFFF -> Dout=4'hF.
REQ-027 Async reset: with Dout=4'h9 and Valid=1, drive rst_n low between edges -> both outputs clear immediately; releasing rst_n with Din=16'h0004 -> Dout=4'h2, Valid=1 after the next edge.

Source files
------------

// File: rtl/exp_priority16_if.sv
// rtl/exp_priority16_if.sv - request/result bundle for the 16-bit priority encoder
interface exp_priority16_if;
    logic [15:0] Din;
    logic        En;
    logic [3:0]  Dout;
    logic        Valid;

    modport master (
        output Din,
        output En,
        input  Dout,
        input  Valid
    );

    modport slave (
        input  Din,
        input  En,
        output Dout,
        output Valid
    );
endinterface

// File: rtl/exp_priority16.sv
// rtl/exp_priority16.sv - registered 16-bit priority encoder, bit 15 highest, active-low enable
module exp_priority16 (
    input  logic               clk,
    input  logic               rst_n,
    exp_priority16_if.slave    bus
);

    logic [3:0] w_idx;
    logic       w_found;
    logic [3:0] r_dout;
    logic       r_valid;

    // Once a 1 is found the !w_found term blocks lower bits, so X/Z below the winner never reach the result.
    always_comb begin
        w_idx   = 4'h0;
        w_found = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (!w_found && bus.Din[i] === 1'b1) begin
                w_idx   = 4'(i);
                w_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout  <= 4'h0;
            r_valid <= 1'b0;
        end else if (bus.En) begin
            r_dout  <= 4'h0;
            r_valid <= 1'b0;
        end else begin
            r_dout  <= w_idx;
            r_valid <= w_found;
        end
    end

    assign bus.Dout  = r_dout;
    assign bus.Valid = r_valid;

endmodule

// File: tb/tb_exp_priority16.sv
// tb/tb_exp_priority16.sv - scoreboard bench for exp_priority16
module tb_exp_priority16;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [4:0] exp_q[$];
    logic [4:0] exp_item;

    exp_priority16_if bus_if ();

    exp_priority16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got dout=%h valid=%b expected dout=%h valid=%b",
                     tag, got[4:1], got[0], exp[4:1], exp[0]);
        end
    endtask

    function automatic logic [4:0] model(input logic [15:0] d, input logic en);
        if (en !== 1'b0) return 5'b0;
        for (int i = 15; i >= 0; i--) begin
            if (d[i] === 1'b1) return {4'(i), 1'b1};
        end
        return 5'b0;
    endfunction

    task automatic drive(input logic [15:0] d, input logic en, input logic [4:0] exp);
        @(negedge clk);
        bus_if.Din = d;
        bus_if.En  = en;
        exp_q.push_back(exp);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_item = exp_q.pop_front();
            check("scoreboard", {bus_if.Dout, bus_if.Valid}, exp_item);
        end
    end

    initial begin
        logic [15:0] d;
        int          wait_cycles;
        checks = 0;
        errors = 0;
        rst_n      = 1'b0;
        bus_if.Din = 16'h0000;
        bus_if.En  = 1'b1;
        #1;
        check("reset_state", {bus_if.Dout, bus_if.Valid}, 5'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 16; k++) begin
            d = 16'bx;
            for (int j = 15; j > k; j--) d[j] = 1'b0;
            d[k] = 1'b1;
            drive(d, 1'b0, {4'(k), 1'b1});
        end

        drive(16'h0000, 1'b0, 5'b0);
        drive(16'h8001, 1'b1, 5'b0);
        drive(16'h8001, 1'b0, {4'hF, 1'b1});
        drive(16'hxxxx, 1'b1, 5'b0);
        drive(16'h0A50, 1'b0, {4'hB, 1'b1});
        drive(16'hFFFF, 1'b0, {4'hF, 1'b1});
        drive(16'h0001, 1'b0, {4'h0, 1'b1});

        for (int n = 0; n < 24; n++) begin
            d = 16'($urandom) >> $urandom_range(0, 15);
            drive(d, 1'b0, model(d, 1'b0));
        end

        drive(16'h0200, 1'b0, {4'h9, 1'b1});
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", {bus_if.Dout, bus_if.Valid}, 5'b0);
        bus_if.Din = 16'h0004;
        @(posedge clk);
        #1;
        check("reset_hold", {bus_if.Dout, bus_if.Valid}, 5'b0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back({4'h2, 1'b1});

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(negedge clk);
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
